// File: rtl/pc_pkg.sv
// Shared definitions for the instruction-fetch PC controller: FSM encoding,
// default alignment parameters and the target alignment check.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_INC = 4;
    localparam int unsigned ALIGN_BITS  = $clog2(DEFAULT_INC);

    // inc is a power of two, so alignment is a mask test on the low bits.
    function automatic logic is_aligned(input logic [31:0] addr, input int unsigned inc);
        return (addr & (inc - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// Ripple-carry incrementer: a full-adder chain adding the constant INC to a.
// Wraps modulo 2^ADDR_W; the final carry is intentionally not formed.
module pc_adder #(
    parameter int          ADDR_W = 8,
    parameter int unsigned INC    = 4
) (
    input  logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] sum
);

    localparam logic [ADDR_W-1:0] B = ADDR_W'(INC);

    logic [ADDR_W-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < ADDR_W; i++) begin : g_fa
        assign sum[i] = a[i] ^ B[i] ^ c[i];
        if (i < ADDR_W - 1) begin : g_carry
            assign c[i+1] = (a[i] & B[i]) | (c[i] & (a[i] ^ B[i]));
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control for the IF stage: sequential advance,
// jump/branch redirect with one-cycle bubble, stall hold, misalign reporting.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int unsigned       INC      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              pcsrc,
    output logic              if_valid,
    output logic              redirect,
    output logic              misalign_err,
    output logic [1:0]        state_dbg
);

    state_e            state;
    logic              active;
    logic              want_redirect;
    logic              tgt_aligned;
    logic [ADDR_W-1:0] tgt;

    pc_adder #(.ADDR_W(ADDR_W), .INC(INC)) u_adder (
        .a   (pc),
        .sum (pc_next_seq)
    );

    // Qualifiers towards IF/ID: if_valid=1 means pc is a real fetch to latch;
    // redirect=1 means the fetch currently in IF/ID is wrong and must be
    // flushed. There is no back-pressure other than stall.
    assign active        = (state != BOOT);
    assign pcsrc         = active & branch & zero_flag;
    assign want_redirect = active & (jump | pcsrc);
    assign tgt           = jump ? jump_target : branch_target;
    assign tgt_aligned   = is_aligned(32'(tgt), INC);
    assign redirect      = want_redirect & tgt_aligned;
    assign if_valid      = (state == RUN);
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            state        <= BOOT;
            misalign_err <= 1'b0;
        end else begin
            if (want_redirect && !tgt_aligned) begin
                misalign_err <= 1'b1;
            end
            // Redirect wins over stall; a rejected target falls through to
            // the ordinary stall/sequential behaviour.
            case (state)
                BOOT: state <= RUN;
                default: begin
                    if (redirect) begin
                        pc    <= tgt;
                        state <= BUBBLE;
                    end else if (!stall) begin
                        pc    <= pc_next_seq;
                        state <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl (ADDR_W=8, INC=4, RESET_PC=0) with a
// scoreboard queue of hand-computed expected outputs per checked cycle.
module tb_pc_fetch_ctrl;

    localparam int W = 20;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       branch;
    logic       zero_flag;
    logic [7:0] branch_target;
    logic       jump;
    logic [7:0] jump_target;
    logic [7:0] pc;
    logic [7:0] pc_next_seq;
    logic       pcsrc;
    logic       if_valid;
    logic       redirect;
    logic       misalign_err;
    logic [1:0] state_dbg;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    pc_fetch_ctrl #(.ADDR_W(8), .INC(4), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch        (branch),
        .zero_flag     (zero_flag),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_next_seq   (pc_next_seq),
        .pcsrc         (pcsrc),
        .if_valid      (if_valid),
        .redirect      (redirect),
        .misalign_err  (misalign_err),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: apply one cycle of inputs at the falling edge, push expectation
    task automatic step(input logic rst, input logic st, input logic br, input logic zf,
                        input logic [7:0] bt, input logic jp, input logic [7:0] jt,
                        input logic [7:0] e_pc, input logic e_valid, input logic e_pcsrc,
                        input logic e_redir, input logic e_mis, input string nm);
        logic [7:0] e_seq;
        @(negedge clk);
        rst_n         = rst;
        stall         = st;
        branch        = br;
        zero_flag     = zf;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        e_seq = e_pc + 8'd4;
        exp_q.push_back({e_pc, e_seq, e_valid, e_pcsrc, e_redir, e_mis});
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        string        nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {pc, pc_next_seq, if_valid, pcsrc, redirect, misalign_err};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s: got pc=%h seq=%h valid=%b pcsrc=%b redir=%b mis=%b, expected pc=%h seq=%h valid=%b pcsrc=%b redir=%b mis=%b",
                             nm, got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                             exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    // stimulus:   rst st br zf bt     jp jt      e_pc   v  ps rd ms
    initial begin
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero_flag = 1'b0;
        branch_target = 8'h00; jump = 1'b0; jump_target = 8'h00;

        step(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 8'h00, 1, 8'h40, 8'h00, 0, 0, 0, 0, "boot_ignores_jump");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, "run_pc0");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0, 0, 0, "seq_04");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h08, 1, 0, 0, 0, "seq_08");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h0C, 1, 0, 0, 0, "seq_0c");
        step(1, 0, 1, 1, 8'h40, 0, 8'h00, 8'h10, 1, 1, 1, 0, "branch_taken");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h40, 0, 0, 0, 0, "branch_bubble");
        step(1, 0, 0, 0, 8'h00, 1, 8'h10, 8'h44, 1, 0, 1, 0, "jump_back_10");
        step(1, 0, 1, 0, 8'h40, 0, 8'h00, 8'h10, 0, 0, 0, 0, "branch_not_taken");
        step(1, 1, 1, 1, 8'h40, 1, 8'h80, 8'h14, 1, 1, 1, 0, "jump_over_branch_stall");
        step(1, 0, 0, 0, 8'h00, 1, 8'h1C, 8'h80, 0, 0, 1, 0, "back_to_back_redirect");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h1C, 0, 0, 0, 0, "second_bubble");
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 0, "stall_1");
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 0, "stall_2");
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 0, "stall_3");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 0, "stall_release");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h24, 1, 0, 0, 0, "after_stall_24");
        step(1, 0, 0, 0, 8'h00, 1, 8'h42, 8'h28, 1, 0, 0, 0, "misaligned_jump");
        step(1, 0, 0, 0, 8'h00, 1, 8'h48, 8'h2C, 1, 0, 1, 1, "sticky_then_aligned");
        step(1, 0, 0, 0, 8'h00, 1, 8'hFC, 8'h48, 0, 0, 1, 1, "jump_to_fc");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFC, 0, 0, 0, 1, "wrap_seq");
        step(1, 1, 0, 0, 8'h00, 1, 8'h61, 8'h00, 1, 0, 0, 1, "misaligned_under_stall");
        step(1, 0, 0, 0, 8'h00, 1, 8'h50, 8'h00, 1, 0, 1, 1, "jump_50");
        step(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, "reset_mid_bubble");
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, "boot_ignores_stall");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, "rerun_pc0");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0, 0, 0, "rerun_pc4");

        // let the monitor drain, with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
